com_slink_diag_mc: RTL and testbench

//  Multi-channel, parametrised SLINK link-health diagnoser with per-channel fault counters.
//  - Counts per-channel packet errors: length, tick, CRC, delay.
//  - Leaky-bucket decay: isolated errors on an otherwise healthy link drain away.
//  - Sticky fault flags: held until software clears them.
//  - Outputs: masked per-channel slink_err plus an OR summary.
//  - Sits between the SLINK receive channels and the self-monitor (selfm) fault aggregator.

---
 rtl/com_slink_diag_pkg.sv | 24 ++
 rtl/com_slink_diag_chn.sv | 101 ++++++++++
 rtl/com_slink_diag_mc.sv | 73 +++++++
 tb/tb_com_slink_diag_mc.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_slink_diag_pkg.sv
// Shared constants for the SLINK link-health diagnoser: error-bit layout and a width helper.
package com_slink_diag_pkg;

    localparam int ERR_NUM = 5;
    localparam int BREAK   = 4;
    localparam int LEN     = 3;
    localparam int TICK    = 2;
    localparam int CRC     = 1;
    localparam int DLY     = 0;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/com_slink_diag_chn.sv
// One SLINK channel: saturating error counters with leaky-bucket decay and sticky fault flags.
module com_slink_diag_chn
    import com_slink_diag_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int LEN_THR   = 5,
    parameter int TICK_THR  = 50,
    parameter int CRC_THR   = 5,
    parameter int DLY_THR   = 5,
    parameter int LEAK_PKTS = 16
) (
    input  logic               clk_12_5m,
    input  logic               rst_12_5m,
    input  logic               enable,
    input  logic               break_err,
    input  logic               len_err,
    input  logic               tick_err,
    input  logic               crc_err,
    input  logic               delay_err,
    input  logic               eop,
    input  logic               clr,
    output logic [ERR_NUM-1:0] flags,
    output logic [CNT_W-1:0]   crc_cnt
);

    localparam int GOOD_W = clog2(LEAK_PKTS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   len_cnt_r;
    logic [CNT_W-1:0]   tick_cnt_r;
    logic [CNT_W-1:0]   crc_cnt_r;
    logic [CNT_W-1:0]   dly_cnt_r;
    logic [GOOD_W-1:0]  good_cnt_r;
    logic [ERR_NUM-2:0] sticky_r;
    logic               break_r;
    logic               clean_s;
    logic               good_s;
    logic               leak_s;

    // A simultaneous increment and leak cancel; otherwise saturate at both ends.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            nxt = (cnt == '0) ? cnt : cnt - CNT_W'(1);
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    function automatic logic at_thr(input logic [CNT_W-1:0] cnt, input int thr);
        return (32'(cnt) >= thr);
    endfunction

    // Packet classification and leak-step decode
    always_comb begin
        clean_s = clr | ~enable;
        good_s  = eop & ~len_err & ~tick_err & ~crc_err;
        leak_s  = good_s & (good_cnt_r == GOOD_W'(LEAK_PKTS - 1));
    end

    // Counter, good-packet and flag state
    always_ff @(posedge clk_12_5m or posedge rst_12_5m) begin
        if (rst_12_5m) begin
            len_cnt_r  <= '0;
            tick_cnt_r <= '0;
            crc_cnt_r  <= '0;
            dly_cnt_r  <= '0;
            good_cnt_r <= '0;
            sticky_r   <= '0;
            break_r    <= 1'b0;
        end else if (clean_s) begin
            len_cnt_r  <= '0;
            tick_cnt_r <= '0;
            crc_cnt_r  <= '0;
            dly_cnt_r  <= '0;
            good_cnt_r <= '0;
            sticky_r   <= '0;
            break_r    <= enable & break_err;
        end else begin
            len_cnt_r  <= cnt_next(len_cnt_r,  eop & len_err,  leak_s);
            tick_cnt_r <= cnt_next(tick_cnt_r, eop & tick_err, leak_s);
            crc_cnt_r  <= cnt_next(crc_cnt_r,  eop & crc_err,  leak_s);
            dly_cnt_r  <= cnt_next(dly_cnt_r,  delay_err,      leak_s);
            good_cnt_r <= good_s ? good_cnt_r + GOOD_W'(1) : good_cnt_r;
            sticky_r   <= sticky_r | {at_thr(len_cnt_r,  LEN_THR),
                                      at_thr(tick_cnt_r, TICK_THR),
                                      at_thr(crc_cnt_r,  CRC_THR),
                                      at_thr(dly_cnt_r,  DLY_THR)};
            break_r    <= break_err;
        end
    end

    assign flags   = {break_r, sticky_r};
    assign crc_cnt = crc_cnt_r;

endmodule

// File: rtl/com_slink_diag_mc.sv
// Multi-channel SLINK link-health diagnoser: per-channel diag instances, enable masking, summary and debug view.
module com_slink_diag_mc
    import com_slink_diag_pkg::*;
#(
    parameter int NCHN      = 4,
    parameter int CNT_W     = 8,
    parameter int LEN_THR   = 5,
    parameter int TICK_THR  = 50,
    parameter int CRC_THR   = 5,
    parameter int DLY_THR   = 5,
    parameter int LEAK_PKTS = 16
) (
    input  logic                    clk_12_5m,
    input  logic                    rst_12_5m,
    input  logic [NCHN-1:0]         chn_enable,
    input  logic [NCHN-1:0]         chn_break_err,
    input  logic [NCHN-1:0]         chn_pkt_len_err,
    input  logic [NCHN-1:0]         chn_pkt_tick_err,
    input  logic [NCHN-1:0]         chn_pkt_crc_err,
    input  logic [NCHN-1:0]         chn_pkt_delay_err,
    input  logic [NCHN-1:0]         chn_pkt_eop,
    input  logic [NCHN-1:0]         err_clr,
    input  logic [3:0]              dbg_sel,
    output logic [NCHN-1:0]         slink_err,
    output logic                    slink_err_any,
    output logic [NCHN*ERR_NUM-1:0] err_flags,
    output logic [15:0]             debug_bus
);

    logic [ERR_NUM-1:0] chn_flags_s [NCHN];
    logic [CNT_W-1:0]   chn_crc_s   [NCHN];
    logic [15:0]        debug_tbl_s [16];

    for (genvar i = 0; i < NCHN; i++) begin : g_chn
        logic [CNT_W+7:0] crc_ext_s;

        com_slink_diag_chn #(
            .CNT_W     (CNT_W),
            .LEN_THR   (LEN_THR),
            .TICK_THR  (TICK_THR),
            .CRC_THR   (CRC_THR),
            .DLY_THR   (DLY_THR),
            .LEAK_PKTS (LEAK_PKTS)
        ) u_chn (
            .clk_12_5m (clk_12_5m),
            .rst_12_5m (rst_12_5m),
            .enable    (chn_enable[i]),
            .break_err (chn_break_err[i]),
            .len_err   (chn_pkt_len_err[i]),
            .tick_err  (chn_pkt_tick_err[i]),
            .crc_err   (chn_pkt_crc_err[i]),
            .delay_err (chn_pkt_delay_err[i]),
            .eop       (chn_pkt_eop[i]),
            .clr       (err_clr[i]),
            .flags     (chn_flags_s[i]),
            .crc_cnt   (chn_crc_s[i])
        );

        // Zero-extend so narrow counters still fill the 8-bit debug field
        assign crc_ext_s = {8'd0, chn_crc_s[i]};
        assign err_flags[i*ERR_NUM +: ERR_NUM] = chn_flags_s[i];
        assign slink_err[i] = chn_enable[i] & (|chn_flags_s[i]);
        assign debug_tbl_s[i] = {chn_flags_s[i], 3'b000, crc_ext_s[7:0]};
    end

    for (genvar i = NCHN; i < 16; i++) begin : g_dbg_pad
        assign debug_tbl_s[i] = 16'd0;
    end

    assign slink_err_any = |slink_err;
    assign debug_bus     = debug_tbl_s[dbg_sel];

endmodule

// File: tb/tb_com_slink_diag_mc.sv
// Self-checking bench for com_slink_diag_mc: directed scenarios plus randomized traffic against a counting model.
module tb_com_slink_diag_mc;

    localparam int NCHN = 4;
    localparam int CMAX = 255;
    localparam int LEAK = 16;
    localparam int THR [4] = '{5, 50, 5, 5};   // len, tick, crc, delay

    logic            clk_12_5m = 1'b0;
    logic            rst_12_5m = 1'b1;
    logic [NCHN-1:0] chn_enable = '1;
    logic [NCHN-1:0] chn_break_err = '0;
    logic [NCHN-1:0] chn_pkt_len_err = '0;
    logic [NCHN-1:0] chn_pkt_tick_err = '0;
    logic [NCHN-1:0] chn_pkt_crc_err = '0;
    logic [NCHN-1:0] chn_pkt_delay_err = '0;
    logic [NCHN-1:0] chn_pkt_eop = '0;
    logic [NCHN-1:0] err_clr = '0;
    logic [3:0]      dbg_sel = 4'd0;
    logic [NCHN-1:0] slink_err;
    logic            slink_err_any;
    logic [NCHN*5-1:0] err_flags;
    logic [15:0]     debug_bus;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    // Reference model: plain integer counts, good-packet tally, sticky bits {len,tick,crc,dly}
    int       m_cnt  [NCHN][4];
    int       m_good [NCHN];
    logic [3:0] m_st [NCHN];
    logic     m_brk  [NCHN];

    com_slink_diag_mc dut (
        .clk_12_5m         (clk_12_5m),
        .rst_12_5m         (rst_12_5m),
        .chn_enable        (chn_enable),
        .chn_break_err     (chn_break_err),
        .chn_pkt_len_err   (chn_pkt_len_err),
        .chn_pkt_tick_err  (chn_pkt_tick_err),
        .chn_pkt_crc_err   (chn_pkt_crc_err),
        .chn_pkt_delay_err (chn_pkt_delay_err),
        .chn_pkt_eop       (chn_pkt_eop),
        .err_clr           (err_clr),
        .dbg_sel           (dbg_sel),
        .slink_err         (slink_err),
        .slink_err_any     (slink_err_any),
        .err_flags         (err_flags),
        .debug_bus         (debug_bus)
    );

    always #40 clk_12_5m = ~clk_12_5m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NCHN; c++) begin
            for (int t = 0; t < 4; t++) m_cnt[c][t] = 0;
            m_good[c] = 0;
            m_st[c]   = 4'b0000;
            m_brk[c]  = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic m_edge();
        int inc [4];
        int v;
        logic good_pkt;
        logic leak;
        if (rst_12_5m) begin
            m_reset();
            return;
        end
        for (int c = 0; c < NCHN; c++) begin
            if (!chn_enable[c] || err_clr[c]) begin
                for (int t = 0; t < 4; t++) m_cnt[c][t] = 0;
                m_good[c] = 0;
                m_st[c]   = 4'b0000;
                m_brk[c]  = chn_enable[c] & chn_break_err[c];
            end else begin
                for (int t = 0; t < 4; t++) begin
                    if (m_cnt[c][t] >= THR[t]) m_st[c][3-t] = 1'b1;
                end
                good_pkt = chn_pkt_eop[c] & ~chn_pkt_len_err[c] & ~chn_pkt_tick_err[c]
                           & ~chn_pkt_crc_err[c];
                leak = good_pkt && (m_good[c] == LEAK - 1);
                if (good_pkt) m_good[c] = (m_good[c] + 1) % LEAK;
                inc[0] = int'(chn_pkt_eop[c] & chn_pkt_len_err[c]);
                inc[1] = int'(chn_pkt_eop[c] & chn_pkt_tick_err[c]);
                inc[2] = int'(chn_pkt_eop[c] & chn_pkt_crc_err[c]);
                inc[3] = int'(chn_pkt_delay_err[c]);
                for (int t = 0; t < 4; t++) begin
                    v = m_cnt[c][t] + inc[t] - int'(leak);
                    if (v < 0) v = 0;
                    if (v > CMAX) v = CMAX;
                    m_cnt[c][t] = v;
                end
                m_brk[c] = chn_break_err[c];
            end
        end
    endtask

    task automatic check_all();
        logic [NCHN-1:0]   e_slink;
        logic [NCHN*5-1:0] e_flags;
        logic [15:0]       e_dbg;
        logic [7:0]        crc8;
        for (int c = 0; c < NCHN; c++) begin
            e_flags[c*5 +: 5] = {m_brk[c], m_st[c]};
            e_slink[c] = chn_enable[c] & (m_brk[c] | (|m_st[c]));
        end
        e_dbg = 16'd0;
        if (int'(dbg_sel) < NCHN) begin
            crc8  = 8'(m_cnt[dbg_sel][2]);
            e_dbg = {m_brk[dbg_sel], m_st[dbg_sel], 3'b000, crc8};
        end
        chk("slink_err", 64'(slink_err), 64'(e_slink));
        chk("slink_err_any", 64'(slink_err_any), 64'(|e_slink));
        chk("err_flags", 64'(err_flags), 64'(e_flags));
        chk("debug_bus", 64'(debug_bus), 64'(e_dbg));
    endtask

    task automatic step();
        @(posedge clk_12_5m);
        m_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input int ch, input logic a_eop, input logic a_len,
                         input logic a_tick, input logic a_crc, input logic a_dly);
        chn_pkt_eop       = '0;
        chn_pkt_len_err   = '0;
        chn_pkt_tick_err  = '0;
        chn_pkt_crc_err   = '0;
        chn_pkt_delay_err = '0;
        err_clr           = '0;
        chn_pkt_eop[ch]       = a_eop;
        chn_pkt_len_err[ch]   = a_len;
        chn_pkt_tick_err[ch]  = a_tick;
        chn_pkt_crc_err[ch]   = a_crc;
        chn_pkt_delay_err[ch] = a_dly;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_chn(input int ch);
        idle();
        err_clr[ch] = 1'b1;
        step();
        idle();
    endtask

    initial begin
        m_reset();
        #10;
        check_all();
        chk("reset_debug", 64'(debug_bus), 64'd0);
        repeat (2) step();
        rst_12_5m = 1'b0;

        // T1: five CRC errors on ch0
        dbg_sel = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            step();
        end
        chk("t1_crc_cnt", 64'(debug_bus[7:0]), 64'd5);
        chk("t1_no_fault_yet", 64'(slink_err[0]), 64'd0);
        idle();
        step();
        chk("t1_fault", 64'(slink_err[0]), 64'd1);
        chk("t1_others", 64'(slink_err[3:1]), 64'd0);
        clear_chn(0);

        // T2: four CRC errors on ch1, then leaking good packets
        dbg_sel = 4'd1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            step();
        end
        for (int k = 1; k <= 16; k++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            if (k == 15) chk("t2_cnt_before_leak", 64'(debug_bus[7:0]), 64'd4);
        end
        chk("t2_cnt_after_leak", 64'(debug_bus[7:0]), 64'd3);
        chk("t2_no_fault", 64'(slink_err[1]), 64'd0);
        for (int k = 0; k < 64; k++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("t2_cnt_drained", 64'(debug_bus[7:0]), 64'd0);

        // T3: sticky length fault on ch2, then clear with a coincident error
        dbg_sel = 4'd2;
        for (int k = 0; k < 5; k++) begin
            drive(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        idle();
        step();
        for (int k = 0; k < 80; k++) begin
            drive(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("t3_len_sticky", 64'(err_flags[2*5+3]), 64'd1);
        drive(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        err_clr[2] = 1'b1;
        step();
        chk("t3_clr_flags", 64'(err_flags[2*5 +: 5]), 64'd0);
        chk("t3_clr_crc", 64'(debug_bus[7:0]), 64'd0);
        idle();
        step();
        chk("t3_clr_err_dropped", 64'(debug_bus), 64'd0);

        // T4: tick/CRC saturation on ch3
        dbg_sel = 4'd3;
        for (int k = 1; k <= 300; k++) begin
            drive(3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            step();
            if (k == 50) chk("t4_tick_flag_pre", 64'(err_flags[3*5+2]), 64'd0);
            if (k == 51) chk("t4_tick_flag_set", 64'(err_flags[3*5+2]), 64'd1);
        end
        chk("t4_crc_sat", 64'(debug_bus[7:0]), 64'd255);
        idle();
        step();
        chk("t4_crc_hold", 64'(debug_bus[7:0]), 64'd255);
        clear_chn(3);

        // T5: disabled channel ignores break and errors
        dbg_sel = 4'd0;
        chn_enable[0] = 1'b0;
        chn_break_err[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            step();
        end
        chk("t5_disabled_err", 64'(slink_err[0]), 64'd0);
        chk("t5_disabled_flags", 64'(err_flags[4:0]), 64'd0);
        idle();
        chn_enable[0] = 1'b1;
        #1;
        chk("t5_enable_comb", 64'(slink_err[0]), 64'd0);
        step();
        chk("t5_break_seen", 64'(err_flags[4]), 64'd1);
        chn_break_err[0] = 1'b0;
        step();

        // T6: delay pulse on the leak wrap holds the count (ch1)
        dbg_sel = 4'd1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
        for (int k = 0; k < 15; k++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        step();
        chk("t6_dly_at_4", 64'(err_flags[1*5+0]), 64'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        step();
        chk("t6_dly_at_5", 64'(err_flags[1*5+0]), 64'd1);

        // Async reset in the middle of a burst
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            step();
        end
        #20;
        rst_12_5m = 1'b1;
        #1;
        m_reset();
        check_all();
        chk("rst_any", 64'(slink_err_any), 64'd0);
        chk("rst_flags", 64'(err_flags), 64'd0);
        idle();
        step();
        rst_12_5m = 1'b0;

        // Randomized traffic on all channels
        chn_enable = '1;
        for (int n = 0; n < 600; n++) begin
            if (n % 8 == 0) dbg_sel = 4'($urandom_range(15, 0));
            for (int c = 0; c < NCHN; c++) begin
                if ($urandom_range(99, 0) == 0) chn_enable[c] = ~chn_enable[c];
                if ($urandom_range(29, 0) == 0) chn_break_err[c] = ~chn_break_err[c];
                chn_pkt_eop[c]       = ($urandom_range(2, 0) == 0);
                chn_pkt_len_err[c]   = ($urandom_range(7, 0) == 0);
                chn_pkt_tick_err[c]  = ($urandom_range(3, 0) == 0);
                chn_pkt_crc_err[c]   = ($urandom_range(7, 0) == 0);
                chn_pkt_delay_err[c] = ($urandom_range(9, 0) == 0);
                err_clr[c]           = ($urandom_range(79, 0) == 0);
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
